regfile_port_arbiter: RTL
=========================

// Module: regfile_port_arbiter
// PURPOSE
//  Shares register-file port B between CPU writeback/read traffic and an external debug master.
//  The CPU has priority. A wait counter guarantees the debug master a grant within MAX_WAIT cycles.
//  Placement: between the core and register_file port B. Drives cpu_stall back to the core.
//  Rejects debug writes to the FLAG and DINP registers, which are hardware-owned.
// PARAMETERS
//  MAX_WAIT   4   cycles debug may be blocked by cpu_active before a forced grant (1..7)
//  WAIT_W     3   width of the wait counter; must satisfy 2**WAIT_W > MAX_WAIT
//  FLAG_ADDR  31  address of the flag register (debug write -> error)
//  DINP_ADDR  28  address of the data-input register (debug write -> error)
// PORTS
//  clk            in   1  system clock; all state updates on posedge
//  resetn         in   1  synchronous active-low reset
//  cpu_active     in   1  core needs port B this cycle
//  cpu_b_addr     in   5  core port-B address
//  cpu_b_data_in  in   8  core write data
//  cpu_b_wr       in   1  core write enable
//  cpu_stall      out  1  core must hold its port-B request this cycle
//  dbg_req        in   1  debug request; held with addr/we/wdata stable until dbg_ack
//  dbg_we         in   1  1 = write, 0 = read
//  dbg_addr       in   5  debug register address
//  dbg_wdata      in   8  debug write data
//  dbg_ack        out  1  one-cycle completion pulse
//  dbg_rdata      out  8  read data, valid while dbg_ack = 1
//  dbg_err        out  1  write rejected, valid while dbg_ack = 1
//  rf_b_addr      out  5  to register_file b_addr
//  rf_b_data_in   out  8  to register_file b_data_in
//  rf_b_wr_enable out  1  to register_file b_wr_enable
//  rf_b_data_out  in   8  from register_file b_data_out (combinational read)
// BEHAVIOUR
//  States: IDLE, GRANT, ACK.
//  Reset (resetn = 0 at posedge): state = IDLE, wait_cnt = 0.
//    Registered outputs clear: dbg_ack = 0, dbg_rdata = 0, dbg_err = 0, err_q = 0.
//    Reset mid-transaction drops the transaction; no ack is issued.
//  Port mux:
//    In GRANT: rf_b_addr = dbg_addr; rf_b_data_in = dbg_wdata; rf_b_wr_enable = dbg_we & ~err_q.
//    In IDLE and ACK: the CPU signals pass through unchanged.
//  cpu_stall = cpu_active & (state == GRANT). Purely combinational.
//  IDLE:
//    dbg_req & (~cpu_active | wait_cnt == MAX_WAIT) -> GRANT.
//      Latch err_q = dbg_we & (dbg_addr == FLAG_ADDR | dbg_addr == DINP_ADDR); wait_cnt <= 0.
//    dbg_req & cpu_active & wait_cnt < MAX_WAIT -> stay in IDLE; wait_cnt += 1 (saturates at MAX_WAIT).
//    ~dbg_req -> wait_cnt <= 0.
//  GRANT: exactly one cycle.
//    Any write commits on the closing edge.
//    dbg_rdata <= rf_b_data_out (all accesses); dbg_err <= err_q.
//    -> ACK.
//  ACK: dbg_ack = 1 for one cycle; port returns to the CPU; -> IDLE.
//    dbg_ack, dbg_rdata and dbg_err are registered outputs.
//    dbg_rdata and dbg_err hold their values until the next GRANT.
//  Handshake:
//    The requester must have dbg_req low in the cycle after dbg_ack.
//    If dbg_req is still high in IDLE, it is treated as a new request.
//  Latency: request to ack takes at least 2 cycles and at most MAX_WAIT + 2 cycles.
//  Debug reads of FLAG/DINP are allowed. An erroneous write issues no rf write; dbg_err = 1 with the ack.
//  Simultaneous events:
//    cpu_active and dbg_req with wait_cnt < MAX_WAIT -> the CPU wins.
//    With wait_cnt == MAX_WAIT -> debug wins and the CPU stalls 1 cycle.
//  dbg_req dropped before grant -> wait_cnt clears; no ack.
// TESTING
//  1. Idle core, dbg write addr 5 = 0xA5, then read addr 5 -> ack 2 cycles after each req; rdata = 0xA5; err = 0.
//  2. cpu_active held high, dbg_req at t0 -> no grant for 4 cycles; GRANT at t0+5 with cpu_stall = 1 for one cycle;
//     ack at t0+6.
//  3. dbg write addr 31 (FLAG) = 0xFF -> rf_b_wr_enable stays 0; ack with dbg_err = 1; flag register unchanged.
//  4. dbg read addr 31 -> dbg_err = 0; rdata = current flag value.
//  5. cpu_b_wr to addr 3 during IDLE/ACK -> passes through, stall 0; CPU write in the GRANT cycle -> stalled,
//     completes next cycle.
//  6. resetn low during GRANT -> next cycle IDLE, no ack, dbg_rdata = 0, wait_cnt = 0; new request then completes normally.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
// Shares register-file port B between the core and a debug master.
// The core has priority; a saturating wait counter forces a debug grant after MAX_WAIT blocked cycles.
module regfile_port_arbiter #(
    parameter int         MAX_WAIT  = 4,
    parameter int         WAIT_W    = 3,
    parameter logic [4:0] FLAG_ADDR = 5'd31,
    parameter logic [4:0] DINP_ADDR = 5'd28
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       cpu_active,
    input  logic [4:0] cpu_b_addr,
    input  logic [7:0] cpu_b_data_in,
    input  logic       cpu_b_wr,
    output logic       cpu_stall,
    input  logic       dbg_req,
    input  logic       dbg_we,
    input  logic [4:0] dbg_addr,
    input  logic [7:0] dbg_wdata,
    output logic       dbg_ack,
    output logic [7:0] dbg_rdata,
    output logic       dbg_err,
    output logic [4:0] rf_b_addr,
    output logic [7:0] rf_b_data_in,
    output logic       rf_b_wr_enable,
    input  logic [7:0] rf_b_data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              err_q_reg, err_q_next;
    logic              dbg_ack_reg;
    logic [7:0]        dbg_rdata_reg;
    logic              dbg_err_reg;
    logic              wait_expired;
    logic              bad_write;

    assign wait_expired = (wait_cnt_reg == MAX_CNT);
    // FLAG and DINP are owned by hardware; debug may read them but never write them.
    assign bad_write    = dbg_we & ((dbg_addr == FLAG_ADDR) | (dbg_addr == DINP_ADDR));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            err_q_reg     <= 1'b0;
            dbg_ack_reg   <= 1'b0;
            dbg_rdata_reg <= '0;
            dbg_err_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            err_q_reg    <= err_q_next;
            dbg_ack_reg  <= (state_reg == GRANT);
            if (state_reg == GRANT) begin
                dbg_rdata_reg <= rf_b_data_out;
                dbg_err_reg   <= err_q_reg;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        err_q_next    = err_q_reg;
        case (state_reg)
            IDLE: begin
                if (dbg_req) begin
                    if (!cpu_active || wait_expired) begin
                        state_next    = GRANT;
                        wait_cnt_next = '0;
                        err_q_next    = bad_write;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                    end
                end else begin
                    wait_cnt_next = '0;
                end
            end
            GRANT:   state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rf_b_addr      = cpu_b_addr;
        rf_b_data_in   = cpu_b_data_in;
        rf_b_wr_enable = cpu_b_wr;
        cpu_stall      = 1'b0;
        if (state_reg == GRANT) begin
            rf_b_addr      = dbg_addr;
            rf_b_data_in   = dbg_wdata;
            rf_b_wr_enable = dbg_we & ~err_q_reg;
            cpu_stall      = cpu_active;
        end
    end

    assign dbg_ack   = dbg_ack_reg;
    assign dbg_rdata = dbg_rdata_reg;
    assign dbg_err   = dbg_err_reg;

endmodule
